// File: rtl/epp_pkg.sv
// Shared constants for the EPD scan controller: FSM state codes, update
// mode codes and the 2-bit pixel codes driven onto the source bus.
package epp_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_FRM_START  = 3'd1;
    localparam logic [2:0] ST_LINE_DATA  = 3'd2;
    localparam logic [2:0] ST_LINE_LATCH = 3'd3;
    localparam logic [2:0] ST_LINE_GATE  = 3'd4;
    localparam logic [2:0] ST_FRM_END    = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    // Update modes (code 3 behaves as clear)
    localparam logic [1:0] MODE_STREAM    = 2'd0;
    localparam logic [1:0] MODE_CLEAR     = 2'd1;
    localparam logic [1:0] MODE_FILL      = 2'd2;
    localparam logic [1:0] MODE_CLEAR_ALT = 2'd3;

    // Pixel codes; NOOP pads the rest of a stream line after an abort
    localparam logic [1:0] PIX_CLEAR = 2'b10;
    localparam logic [1:0] PIX_FILL  = 2'b01;
    localparam logic [1:0] PIX_NOOP  = 2'b00;

    // Counter width able to hold 0..limit-1, never narrower than 1 bit
    function automatic int cnt_w(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/epp_line_shifter.sv
// Source-line beat generator: two cycles per beat (cl low with new data,
// then cl high), stalls in stream mode until upstream data is offered,
// and fills with a constant pixel code when fill_en is set.
// Handshake: a beat is taken from pix_data in the cycle where
// pix_valid && pix_ready; pix_ready is only high in a beat's cl-low cycle
// and never while fill_en is set.
module epp_line_shifter import epp_pkg::*; #(
    parameter int H_RES  = 960,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              fill_en,
    input  logic [1:0]        fill_pix,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              cl,
    output logic              first_beat,
    output logic              line_done,
    output logic [DATA_W-1:0] d
);
    localparam int BEATS = H_RES * 2 / DATA_W;
    localparam int BW    = cnt_w(BEATS);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    logic              phase;
    logic [BW-1:0]     beat_cnt;
    logic [DATA_W-1:0] data_q;
    logic              load;
    logic [DATA_W-1:0] load_val;

    // Beat decode; new data is shown on d in the cl-low cycle it is loaded
    always_comb begin
        pix_ready  = run & ~phase & ~fill_en;
        load       = run & ~phase & (fill_en | pix_valid);
        load_val   = fill_en ? {(DATA_W/2){fill_pix}} : pix_data;
        d          = load ? load_val : data_q;
        cl         = run & phase;
        first_beat = run & (beat_cnt == '0);
        line_done  = run & phase & (beat_cnt == BEAT_LAST);
    end

    // Phase/beat counters and held data; counters clear whenever idle
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 1'b0;
            beat_cnt <= '0;
            data_q   <= '0;
        end else if (!run) begin
            phase    <= 1'b0;
            beat_cnt <= '0;
        end else if (!phase) begin
            if (load) begin
                data_q <= load_val;
                phase  <= 1'b1;
            end
        end else begin
            phase    <= 1'b0;
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/epp_scan_ctrl.sv
// EPD panel scan controller: frame/row FSM driving the gate signals and
// sequencing the source line shifter for num_frames waveform frames.
// An abort finishes the line in progress (stream beats padded with NOOP),
// then closes the frame and ends the update.
module epp_scan_ctrl import epp_pkg::*; #(
    parameter int H_RES  = 960,
    parameter int V_RES  = 540,
    parameter int DATA_W = 8,
    parameter int CKV_HI = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        num_frames,
    input  logic              abort,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic              epd_gmode,
    output logic              epd_spv,
    output logic              epd_ckv,
    output logic              epd_stl,
    output logic              epd_le,
    output logic              epd_oe,
    output logic              epd_cl,
    output logic [DATA_W-1:0] epd_d
);
    localparam int RW = cnt_w(V_RES);
    localparam int TW = cnt_w(2 * CKV_HI);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(2 * CKV_HI - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(CKV_HI);

    logic [2:0]    state, state_d;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] row_cnt;
    logic [7:0]    frm_cnt;
    logic [1:0]    mode_q;
    logic [7:0]    nf_q;
    logic          abort_lat;
    logic          aborting;
    logic          line_run, line_done, first_beat, fill_en;
    logic [1:0]    fill_pix;

    // Next-state logic
    always_comb begin
        aborting = abort_lat | abort;
        state_d  = state;
        case (state)
            ST_IDLE:       if (start) state_d = (num_frames == 8'd0) ? ST_FRM_END : ST_FRM_START;
            ST_FRM_START:  if (tcnt == T_LAST) state_d = aborting ? ST_FRM_END : ST_LINE_DATA;
            ST_LINE_DATA:  if (line_done) state_d = ST_LINE_LATCH;
            ST_LINE_LATCH: state_d = ST_LINE_GATE;
            ST_LINE_GATE:  if (tcnt == T_LAST)
                               state_d = (aborting || row_cnt == ROW_LAST) ? ST_FRM_END : ST_LINE_DATA;
            ST_FRM_END:    state_d = (aborting || nf_q == 8'd0 || frm_cnt + 8'd1 == nf_q)
                                     ? ST_DONE : ST_FRM_START;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // State, timing, row/frame counters and latched request fields
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            tcnt      <= '0;
            row_cnt   <= '0;
            frm_cnt   <= '0;
            mode_q    <= MODE_STREAM;
            nf_q      <= '0;
            abort_lat <= 1'b0;
        end else begin
            state <= state_d;
            if ((state == ST_FRM_START || state == ST_LINE_GATE) && tcnt != T_LAST)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            if (state == ST_IDLE && start) begin
                mode_q    <= mode;
                nf_q      <= num_frames;
                frm_cnt   <= '0;
                abort_lat <= 1'b0;
            end else if (state != ST_IDLE && abort) begin
                abort_lat <= 1'b1;
            end
            if (state == ST_FRM_START)
                row_cnt <= '0;
            else if (state == ST_LINE_GATE && tcnt == T_LAST)
                row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            if (state == ST_FRM_END)
                frm_cnt <= frm_cnt + 8'd1;
        end
    end

    // Panel and status outputs decoded from the registered state
    always_comb begin
        line_run  = (state == ST_LINE_DATA);
        fill_en   = (mode_q != MODE_STREAM) | aborting;
        fill_pix  = (mode_q == MODE_STREAM) ? PIX_NOOP :
                    (mode_q == MODE_FILL)   ? PIX_FILL : PIX_CLEAR;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        epd_gmode = (state == ST_FRM_START) || (state == ST_LINE_DATA) ||
                    (state == ST_LINE_LATCH) || (state == ST_LINE_GATE);
        epd_oe    = epd_gmode;
        epd_spv   = (state != ST_FRM_START);
        epd_ckv   = ((state == ST_FRM_START) && (tcnt >= T_HALF)) ||
                    ((state == ST_LINE_GATE) && (tcnt <  T_HALF));
        epd_le    = (state == ST_LINE_LATCH);
        epd_stl   = ~first_beat;
    end

    epp_line_shifter #(
        .H_RES  (H_RES),
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .run        (line_run),
        .fill_en    (fill_en),
        .fill_pix   (fill_pix),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .cl         (epd_cl),
        .first_beat (first_beat),
        .line_done  (line_done),
        .d          (epd_d)
    );

endmodule
